// File: rtl/lsu_store_unit_pkg.sv
// Shared LSU types and helpers: access sizes, store FSM states and the
// store-side truncation that mirrors the load path's zero-extension.
package lsu_store_unit_pkg;

  localparam int unsigned DATA_WIDTH = 64;
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    MEM_B,
    MEM_H,
    MEM_W,
    MEM_D
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE,
    BEAT0,
    BEAT1,
    DONE
  } store_state_e;

  // Keeps the low (1 << size) bytes of a register value and clears the rest.
  function automatic logic [DATA_WIDTH-1:0] trunc_by_size(
    input logic [DATA_WIDTH-1:0] data,
    input mem_size_e             size
  );
    logic [DATA_WIDTH-1:0] result;
    result = '0;
    case (size)
      MEM_B:   result[7:0]  = data[7:0];
      MEM_H:   result[15:0] = data[15:0];
      MEM_W:   result[31:0] = data[31:0];
      default: result       = data;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/store_align.sv
// Places a truncated store value and its byte enables into a two-word
// (128-bit) window starting at the byte offset within the first word.
module store_align
  import lsu_store_unit_pkg::*;
(
  input  logic [2:0]              addr,
  input  mem_size_e               size,
  input  logic [DATA_WIDTH-1:0]   data,
  output logic [2*DATA_WIDTH-1:0] wide_data,
  output logic [2*STRB_WIDTH-1:0] wide_strb,
  output logic                    split
);

  logic [STRB_WIDTH-1:0] size_strb;

  always_comb begin
    case (size)
      MEM_B:   size_strb = 8'h01;
      MEM_H:   size_strb = 8'h03;
      MEM_W:   size_strb = 8'h0F;
      default: size_strb = 8'hFF;
    endcase
    wide_data = {{DATA_WIDTH{1'b0}}, trunc_by_size(data, size)} << {addr, 3'b000};
    wide_strb = {{STRB_WIDTH{1'b0}}, size_strb} << addr;
    split     = |wide_strb[2*STRB_WIDTH-1:STRB_WIDTH];
  end

endmodule

// File: rtl/lsu_store_unit.sv
// RV64I store writer: registers one store, issues one or two aligned
// memory write beats with byte strobes, then pulses completion.
module lsu_store_unit #(
  parameter int unsigned DATA_WIDTH       = 64,
  parameter bit          ALLOW_MISALIGNED = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [63:0]             req_addr,
  input  logic [DATA_WIDTH-1:0]   req_data,
  input  logic [1:0]              req_size,
  output logic                    mem_valid,
  input  logic                    mem_ready,
  output logic [63:0]             mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb,
  output logic                    done_valid,
  output logic                    done_err
);
  import lsu_store_unit_pkg::*;

  store_state_e          state, state_next;
  logic [63:0]           addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  mem_size_e             size_q;
  logic                  err_q;

  logic [127:0] wide_data;
  logic [15:0]  wide_strb;
  logic         split;
  logic [63:0]  word_addr;
  logic [3:0]   req_end;
  logic         req_split;
  logic         accept;

  store_align u_align (
    .addr      (addr_q[2:0]),
    .size      (size_q),
    .data      (data_q),
    .wide_data (wide_data),
    .wide_strb (wide_strb),
    .split     (split)
  );

  // Rejection is decided at acceptance, before the fields are registered,
  // so the crossing test is repeated here on the raw request.
  assign req_end   = {1'b0, req_addr[2:0]} + (4'd1 << req_size);
  assign req_split = req_end > 4'd8;
  assign accept    = req_valid && (state == IDLE);
  assign word_addr = {addr_q[63:3], 3'b000};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      addr_q <= '0;
      data_q <= '0;
      size_q <= MEM_B;
      err_q  <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        addr_q <= req_addr;
        data_q <= req_data;
        size_q <= mem_size_e'(req_size);
        err_q  <= !ALLOW_MISALIGNED && req_split;
      end
    end
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    mem_valid  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_wstrb  = '0;
    done_valid = 1'b0;
    done_err   = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = (!ALLOW_MISALIGNED && req_split) ? DONE : BEAT0;
      end
      BEAT0: begin
        mem_valid = 1'b1;
        mem_addr  = word_addr;
        mem_wdata = wide_data[63:0];
        mem_wstrb = wide_strb[7:0];
        if (mem_ready) state_next = split ? BEAT1 : DONE;
      end
      BEAT1: begin
        mem_valid = 1'b1;
        mem_addr  = word_addr + 64'd8;
        mem_wdata = wide_data[127:64];
        mem_wstrb = wide_strb[15:8];
        if (mem_ready) state_next = DONE;
      end
      DONE: begin
        done_valid = 1'b1;
        done_err   = err_q;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_lsu_store_unit.sv
// Bench for lsu_store_unit: directed cases plus random stores checked
// against a byte-lane reference model; two instances cover both modes.
module tb_lsu_store_unit;

  typedef struct packed {
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  strb;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        use_rej = 1'b0;
  logic [63:0] req_addr = '0;
  logic [63:0] req_data = '0;
  logic [1:0]  req_size = '0;
  logic        mem_ready = 1'b1;

  logic a_req_ready, a_mem_valid, a_done_valid, a_done_err;
  logic r_req_ready, r_mem_valid, r_done_valid, r_done_err;
  logic [63:0] a_mem_addr, a_mem_wdata, r_mem_addr, r_mem_wdata;
  logic [7:0]  a_mem_wstrb, r_mem_wstrb;

  logic        o_req_ready, o_mem_valid, o_done_valid, o_done_err;
  logic [63:0] o_mem_addr, o_mem_wdata;
  logic [7:0]  o_mem_wstrb;

  assign o_req_ready  = use_rej ? r_req_ready  : a_req_ready;
  assign o_mem_valid  = use_rej ? r_mem_valid  : a_mem_valid;
  assign o_mem_addr   = use_rej ? r_mem_addr   : a_mem_addr;
  assign o_mem_wdata  = use_rej ? r_mem_wdata  : a_mem_wdata;
  assign o_mem_wstrb  = use_rej ? r_mem_wstrb  : a_mem_wstrb;
  assign o_done_valid = use_rej ? r_done_valid : a_done_valid;
  assign o_done_err   = use_rej ? r_done_err   : a_done_err;

  always #5 clk = ~clk;

  lsu_store_unit #(.DATA_WIDTH(64), .ALLOW_MISALIGNED(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid && !use_rej), .req_ready(a_req_ready),
    .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
    .mem_valid(a_mem_valid), .mem_ready(mem_ready), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_wstrb(a_mem_wstrb),
    .done_valid(a_done_valid), .done_err(a_done_err)
  );

  lsu_store_unit #(.DATA_WIDTH(64), .ALLOW_MISALIGNED(1'b0)) dut_rej (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid && use_rej), .req_ready(r_req_ready),
    .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
    .mem_valid(r_mem_valid), .mem_ready(mem_ready), .mem_addr(r_mem_addr),
    .mem_wdata(r_mem_wdata), .mem_wstrb(r_mem_wstrb),
    .done_valid(r_done_valid), .done_err(r_done_err)
  );

  int    total = 0;
  int    bad = 0;
  beat_t obs_beats[$];
  beat_t exp_beats[$];
  int    obs_lat, exp_lat, stall_viol;
  logic  obs_err, exp_err, post_ready, post_done;

  function automatic beat_t get_beat(input int i);
    if (i < obs_beats.size()) return obs_beats[i];
    return '1;
  endfunction

  // Reference: place each store byte at its absolute position in a 16-byte
  // window; every word of the window that holds any byte becomes one beat.
  task automatic model(input logic [63:0] a, input logic [63:0] d, input logic [1:0] s,
                       input bit allow);
    logic [7:0] lane [16];
    bit         en   [16];
    int         n, off;
    beat_t      b;
    n   = 1 << s;
    off = int'(a[2:0]);
    exp_beats.delete();
    if (off + n > 8 && !allow) begin
      exp_err = 1'b1;
      exp_lat = 1;
      return;
    end
    exp_err = 1'b0;
    for (int i = 0; i < 16; i++) begin lane[i] = 8'h00; en[i] = 1'b0; end
    for (int i = 0; i < n; i++) begin lane[off+i] = d[8*i +: 8]; en[off+i] = 1'b1; end
    for (int w = 0; w < 2; w++) begin
      b.addr  = (a - 64'(a % 8)) + 64'(8 * w);
      b.wdata = '0;
      b.strb  = '0;
      for (int j = 0; j < 8; j++)
        if (en[8*w+j]) begin b.wdata[8*j +: 8] = lane[8*w+j]; b.strb[j] = 1'b1; end
      if (b.strb != 8'h00) exp_beats.push_back(b);
    end
    exp_lat = exp_beats.size() + 1;
  endtask

  // Issues one store from idle; memory stalls the first `stall` cycles a beat is offered.
  task automatic run_store(input logic [63:0] a, input logic [63:0] d, input logic [1:0] s,
                           input int stall);
    int    left;
    bit    held;
    beat_t hb, cur;
    obs_beats.delete();
    obs_lat = -1; obs_err = 1'bx; stall_viol = 0; held = 1'b0; left = stall;
    post_ready = 1'bx; post_done = 1'bx;
    req_addr = a; req_data = d; req_size = s; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr  = {$urandom, $urandom};
    req_data  = {$urandom, $urandom};
    req_size  = 2'($urandom_range(0, 3));
    for (int cyc = 1; cyc <= 40; cyc++) begin
      cur = {o_mem_addr, o_mem_wdata, o_mem_wstrb};
      if (o_done_valid) begin obs_lat = cyc; obs_err = o_done_err; break; end
      if (held && (!o_mem_valid || cur != hb)) stall_viol++;
      held = 1'b0;
      if (o_mem_valid) begin
        if (left > 0) begin mem_ready = 1'b0; left--; held = 1'b1; hb = cur; end
        else begin mem_ready = 1'b1; obs_beats.push_back(cur); end
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
    end
    mem_ready = 1'b1;
    @(posedge clk); #1;
    post_ready = o_req_ready;
    post_done  = o_done_valid;
  endtask

  task automatic test_reset();
    #12;
    total++;
    if ({a_req_ready, a_mem_valid, a_mem_addr, a_mem_wdata, a_mem_wstrb, a_done_valid, a_done_err}
        !== {1'b1, 1'b0, 64'h0, 64'h0, 8'h0, 1'b0, 1'b0}) begin
      bad++; $display("FAIL reset_outputs got ready=%b valid=%b addr=%h wdata=%h strb=%h done=%b err=%b exp 1/0/0/0/0/0/0",
                      a_req_ready, a_mem_valid, a_mem_addr, a_mem_wdata, a_mem_wstrb, a_done_valid, a_done_err);
    end
    total++;
    if ({r_req_ready, r_mem_valid, r_done_valid} !== 3'b100) begin
      bad++; $display("FAIL reset_outputs_rej got=%b exp=100", {r_req_ready, r_mem_valid, r_done_valid});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_sd_aligned();
    run_store(64'h1000, 64'h1122_3344_5566_7788, 2'd3, 0);
    total++; if (obs_lat !== 2) begin bad++; $display("FAIL sd_latency got=%0d exp=2", obs_lat); end
    total++; if (obs_err !== 1'b0) begin bad++; $display("FAIL sd_err got=%b exp=0", obs_err); end
    total++; if (obs_beats.size() !== 1) begin bad++; $display("FAIL sd_beats got=%0d exp=1", obs_beats.size()); end
    total++;
    if (get_beat(0) !== {64'h1000, 64'h1122_3344_5566_7788, 8'hFF}) begin
      bad++; $display("FAIL sd_beat0 got=%h exp=%h", get_beat(0), {64'h1000, 64'h1122_3344_5566_7788, 8'hFF});
    end
    total++; if (post_done !== 1'b0) begin bad++; $display("FAIL sd_done_pulse_width got=%b exp=0", post_done); end
    total++; if (post_ready !== 1'b1) begin bad++; $display("FAIL sd_ready_after got=%b exp=1", post_ready); end
  endtask

  task automatic test_sb();
    run_store(64'h2005, 64'hFFFF_FFFF_FFFF_FFAB, 2'd0, 0);
    total++; if (obs_lat !== 2) begin bad++; $display("FAIL sb_latency got=%0d exp=2", obs_lat); end
    total++; if (obs_beats.size() !== 1) begin bad++; $display("FAIL sb_beats got=%0d exp=1", obs_beats.size()); end
    total++;
    if (get_beat(0) !== {64'h2000, 64'h0000_AB00_0000_0000, 8'h20}) begin
      bad++; $display("FAIL sb_beat0 got=%h exp=%h", get_beat(0), {64'h2000, 64'h0000_AB00_0000_0000, 8'h20});
    end
  endtask

  task automatic test_split();
    run_store(64'h3006, 64'h0000_0000_DEAD_BEEF, 2'd2, 0);
    total++; if (obs_lat !== 3) begin bad++; $display("FAIL split_latency got=%0d exp=3", obs_lat); end
    total++; if (obs_err !== 1'b0) begin bad++; $display("FAIL split_err got=%b exp=0", obs_err); end
    total++; if (obs_beats.size() !== 2) begin bad++; $display("FAIL split_beats got=%0d exp=2", obs_beats.size()); end
    total++;
    if (get_beat(0) !== {64'h3000, 64'hBEEF_0000_0000_0000, 8'hC0}) begin
      bad++; $display("FAIL split_beat0 got=%h exp=%h", get_beat(0), {64'h3000, 64'hBEEF_0000_0000_0000, 8'hC0});
    end
    total++;
    if (get_beat(1) !== {64'h3008, 64'h0000_0000_0000_DEAD, 8'h03}) begin
      bad++; $display("FAIL split_beat1 got=%h exp=%h", get_beat(1), {64'h3008, 64'h0000_0000_0000_DEAD, 8'h03});
    end
  endtask

  task automatic test_reject();
    use_rej = 1'b1;
    run_store(64'h3006, 64'h0000_0000_DEAD_BEEF, 2'd2, 0);
    total++; if (obs_lat !== 1) begin bad++; $display("FAIL reject_latency got=%0d exp=1", obs_lat); end
    total++; if (obs_err !== 1'b1) begin bad++; $display("FAIL reject_err got=%b exp=1", obs_err); end
    total++; if (obs_beats.size() !== 0) begin bad++; $display("FAIL reject_beats got=%0d exp=0", obs_beats.size()); end
    total++; if (post_ready !== 1'b1) begin bad++; $display("FAIL reject_ready_after got=%b exp=1", post_ready); end
    use_rej = 1'b0;
  endtask

  task automatic test_stall();
    run_store(64'h4000, 64'h0000_0000_A5A5_1234, 2'd1, 4);
    total++; if (obs_lat !== 6) begin bad++; $display("FAIL stall_latency got=%0d exp=6", obs_lat); end
    total++; if (stall_viol !== 0) begin bad++; $display("FAIL stall_stability got=%0d exp=0", stall_viol); end
    total++;
    if (get_beat(0) !== {64'h4000, 64'h0000_0000_0000_1234, 8'h03}) begin
      bad++; $display("FAIL stall_beat0 got=%h exp=%h", get_beat(0), {64'h4000, 64'h0000_0000_0000_1234, 8'h03});
    end
  endtask

  task automatic test_wrap();
    run_store(64'hFFFF_FFFF_FFFF_FFFC, 64'h0123_4567_89AB_CDEF, 2'd3, 0);
    total++; if (obs_lat !== 3) begin bad++; $display("FAIL wrap_latency got=%0d exp=3", obs_lat); end
    total++;
    if (get_beat(0) !== {64'hFFFF_FFFF_FFFF_FFF8, 64'h89AB_CDEF_0000_0000, 8'hF0}) begin
      bad++; $display("FAIL wrap_beat0 got=%h exp=%h", get_beat(0), {64'hFFFF_FFFF_FFFF_FFF8, 64'h89AB_CDEF_0000_0000, 8'hF0});
    end
    total++;
    if (get_beat(1) !== {64'h0, 64'h0000_0000_0123_4567, 8'h0F}) begin
      bad++; $display("FAIL wrap_beat1 got=%h exp=%h", get_beat(1), {64'h0, 64'h0000_0000_0123_4567, 8'h0F});
    end
  endtask

  task automatic test_reset_mid();
    int dones, not_ready;
    dones = 0; not_ready = 0;
    mem_ready = 1'b0;
    req_addr = 64'h5000; req_data = 64'h1234_5678_9ABC_DEF0; req_size = 2'd3; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    total++; if (a_mem_valid !== 1'b1) begin bad++; $display("FAIL midrst_beat_active got=%b exp=1", a_mem_valid); end
    rst_n = 1'b0;
    #1;
    total++;
    if ({a_req_ready, a_mem_valid, a_mem_addr, a_mem_wdata, a_mem_wstrb, a_done_valid, a_done_err}
        !== {1'b1, 1'b0, 64'h0, 64'h0, 8'h0, 1'b0, 1'b0}) begin
      bad++; $display("FAIL midrst_outputs got valid=%b addr=%h wdata=%h strb=%h exp all zero",
                      a_mem_valid, a_mem_addr, a_mem_wdata, a_mem_wstrb);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (a_done_valid) dones++;
      if (!a_req_ready) not_ready++;
      @(posedge clk); #1;
    end
    total++; if (dones !== 0) begin bad++; $display("FAIL midrst_no_done got=%0d exp=0", dones); end
    total++; if (not_ready !== 0) begin bad++; $display("FAIL midrst_ready got=%0d busy cycles exp=0", not_ready); end
  endtask

  task automatic test_back_to_back();
    int accepts, dones;
    accepts = 0; dones = 0;
    req_addr = 64'h6000; req_data = 64'hCAFE_F00D_0BAD_BEEF; req_size = 2'd3;
    for (int k = 0; k < 9; k++) begin
      if (a_req_ready) accepts++;
      if (a_done_valid) dones++;
      req_valid = 1'b1;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    @(posedge clk); #1;
    total++; if (accepts !== 3) begin bad++; $display("FAIL b2b_accepts got=%0d exp=3", accepts); end
    total++; if (dones !== 3) begin bad++; $display("FAIL b2b_dones got=%0d exp=3", dones); end
  endtask

  task automatic test_random();
    logic [63:0] a, d;
    logic [1:0]  s;
    int          st;
    for (int it = 0; it < 40; it++) begin
      a = {$urandom, $urandom};
      if (it % 5 == 0) a[63:3] = '1;
      d  = {$urandom, $urandom};
      s  = 2'($urandom_range(0, 3));
      st = $urandom_range(0, 2);
      use_rej = ($urandom_range(0, 3) == 0);
      model(a, d, s, !use_rej);
      run_store(a, d, s, st);
      total++;
      if (obs_lat !== exp_lat + ((exp_beats.size() > 0) ? st : 0)) begin
        bad++; $display("FAIL rnd_latency it=%0d got=%0d exp=%0d", it, obs_lat,
                        exp_lat + ((exp_beats.size() > 0) ? st : 0));
      end
      total++; if (obs_err !== exp_err) begin bad++; $display("FAIL rnd_err it=%0d got=%b exp=%b", it, obs_err, exp_err); end
      total++;
      if (obs_beats.size() !== exp_beats.size()) begin
        bad++; $display("FAIL rnd_beats it=%0d got=%0d exp=%0d", it, obs_beats.size(), exp_beats.size());
      end
      for (int i = 0; i < exp_beats.size(); i++) begin
        total++;
        if (get_beat(i) !== exp_beats[i]) begin
          bad++; $display("FAIL rnd_beat it=%0d beat=%0d got=%h exp=%h", it, i, get_beat(i), exp_beats[i]);
        end
      end
      total++; if (stall_viol !== 0) begin bad++; $display("FAIL rnd_stability it=%0d got=%0d exp=0", it, stall_viol); end
      total++; if (post_done !== 1'b0) begin bad++; $display("FAIL rnd_pulse it=%0d got=%b exp=0", it, post_done); end
      use_rej = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_sd_aligned();
    test_sb();
    test_split();
    test_reject();
    test_stall();
    test_wrap();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
